// File: rtl/eeg_aram_pkg.sv
// Shared ARAM definitions: command one-hot codes, bus widths and the
// read-sequencer state encoding.
package eeg_aram_pkg;

   localparam int ARAM_CMD_DW = 8;
   localparam int ARAM_NUM_DW = 4;
   localparam int ARAM_ADD_AW = 12;
   localparam int SEQ_LEN_DW  = 12;

   localparam logic [ARAM_CMD_DW-1:0] ARAM_CMD_IDLE = 8'b0000_0001;
   localparam logic [ARAM_CMD_DW-1:0] ARAM_CMD_ITOA = 8'b0000_0010;
   localparam logic [ARAM_CMD_DW-1:0] ARAM_CMD_CONV = 8'b0000_0100;
   localparam logic [ARAM_CMD_DW-1:0] ARAM_CMD_OTOA = 8'b0000_1000;
   localparam logic [ARAM_CMD_DW-1:0] ARAM_CMD_WTOA = 8'b0001_0000;
   localparam logic [ARAM_CMD_DW-1:0] ARAM_CMD_ATOW = 8'b0010_0000;
   localparam logic [ARAM_CMD_DW-1:0] ARAM_CMD_ATOA = 8'b0100_0000;
   localparam logic [ARAM_CMD_DW-1:0] ARAM_CMD_READ = 8'b1000_0000;

   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_CMD  = 2'd1,
      SEQ_ADDR = 2'd2,
      SEQ_WAIT = 2'd3
   } seq_state_e;

   // True when every bank selected in mask has its flag set.
   function automatic logic mask_covered(input logic [ARAM_NUM_DW-1:0] flags,
                                         input logic [ARAM_NUM_DW-1:0] mask);
      return ((flags & mask) == mask);
   endfunction

endpackage

// File: rtl/eeg_aram_rd_seq_if.sv
// Bus bundle between the layer controller / ARAM and the read sequencer.
// slave is the sequencer's view, master is the environment's view.
interface eeg_aram_rd_seq_if;
   import eeg_aram_pkg::*;

   logic                                    is_idle;
   logic                                    cfg_vld;
   logic                                    cfg_rdy;
   logic [ARAM_NUM_DW-1:0]                  cfg_mask;
   logic [ARAM_ADD_AW-1:0]                  cfg_base;
   logic [SEQ_LEN_DW-1:0]                   cfg_len;
   logic [ARAM_ADD_AW-1:0]                  cfg_strd;
   logic                                    info_vld;
   logic                                    info_rdy;
   logic [ARAM_CMD_DW-1:0]                  info_cmd;
   logic [ARAM_NUM_DW-1:0]                  info_idx;
   logic [ARAM_NUM_DW-1:0]                  add_vld;
   logic [ARAM_NUM_DW-1:0]                  add_lst;
   logic [ARAM_NUM_DW-1:0]                  add_rdy;
   logic [ARAM_NUM_DW-1:0][ARAM_ADD_AW-1:0] add_add;
   logic [ARAM_NUM_DW-1:0]                  mon_vld;
   logic [ARAM_NUM_DW-1:0]                  mon_rdy;
   logic [ARAM_NUM_DW-1:0]                  mon_lst;
   logic                                    done;

   modport slave (
      output is_idle, cfg_rdy, info_vld, info_cmd, info_idx,
             add_vld, add_lst, add_add, done,
      input  cfg_vld, cfg_mask, cfg_base, cfg_len, cfg_strd,
             info_rdy, add_rdy, mon_vld, mon_rdy, mon_lst
   );

   modport master (
      input  is_idle, cfg_rdy, info_vld, info_cmd, info_idx,
             add_vld, add_lst, add_add, done,
      output cfg_vld, cfg_mask, cfg_base, cfg_len, cfg_strd,
             info_rdy, add_rdy, mon_vld, mon_rdy, mon_lst
   );

endinterface

// File: rtl/eeg_aram_bank_agu.sv
// Per-bank address generator: beat counter, strided address accumulator,
// and the address-done / data-done completion flags for one ARAM bank.
module eeg_aram_bank_agu
   import eeg_aram_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   sel_i,
   input  logic                   clr_dat_i,
   input  logic                   load_i,
   input  logic                   addr_en_i,
   input  logic                   trk_i,
   input  logic [ARAM_ADD_AW-1:0] base_i,
   input  logic [ARAM_ADD_AW-1:0] strd_i,
   input  logic [SEQ_LEN_DW-1:0]  len_i,
   input  logic                   add_rdy_i,
   input  logic                   mon_vld_i,
   input  logic                   mon_rdy_i,
   input  logic                   mon_lst_i,
   output logic                   add_vld_o,
   output logic                   add_lst_o,
   output logic [ARAM_ADD_AW-1:0] add_add_o,
   output logic                   addr_done_nx_o,
   output logic                   dat_done_nx_o
);

   logic [SEQ_LEN_DW-1:0]  cnt_q, cnt_d;
   logic [ARAM_ADD_AW-1:0] addr_q, addr_d;
   logic                   addr_done_q, addr_done_d;
   logic                   dat_done_q, dat_done_d;
   logic                   add_hs;
   logic                   mon_end;

   // Outputs decode registers only; no path from add_rdy_i.
   assign add_vld_o = sel_i & addr_en_i & ~addr_done_q;
   assign add_lst_o = add_vld_o & (cnt_q == len_i);
   assign add_add_o = sel_i ? addr_q : {ARAM_ADD_AW{1'b0}};

   assign add_hs  = add_vld_o & add_rdy_i;
   assign mon_end = sel_i & trk_i & mon_vld_i & mon_rdy_i & mon_lst_i;

   // The FSM looks one edge ahead so it can leave ADDR/WAIT on the handshake cycle.
   assign addr_done_nx_o = addr_done_d;
   assign dat_done_nx_o  = dat_done_d;

   // Next-state for counter, address accumulator and completion flags.
   always_comb begin
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      addr_done_d = addr_done_q;
      dat_done_d  = dat_done_q;
      if (load_i) begin
         cnt_d       = {SEQ_LEN_DW{1'b0}};
         addr_d      = base_i;
         addr_done_d = 1'b0;
      end else if (add_hs) begin
         if (add_lst_o) begin
            addr_done_d = 1'b1;
         end else begin
            cnt_d  = cnt_q + {{(SEQ_LEN_DW-1){1'b0}}, 1'b1};
            addr_d = addr_q + strd_i;   // wraps modulo 2^ARAM_ADD_AW
         end
      end else begin
         addr_done_d = addr_done_q;
      end
      if (clr_dat_i) begin
         dat_done_d = 1'b0;
      end else if (mon_end) begin
         dat_done_d = 1'b1;
      end else begin
         dat_done_d = dat_done_q;
      end
   end

   // Bank state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= {SEQ_LEN_DW{1'b0}};
         addr_q      <= {ARAM_ADD_AW{1'b0}};
         addr_done_q <= 1'b0;
         dat_done_q  <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         addr_done_q <= addr_done_d;
         dat_done_q  <= dat_done_d;
      end
   end

endmodule

// File: rtl/eeg_aram_rd_seq.sv
// ARAM read sequencer: accepts one read job, issues the READ command,
// streams strided addresses into each selected bank and pulses DONE once
// every selected bank has returned its last data beat.
module eeg_aram_rd_seq
   import eeg_aram_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   eeg_aram_rd_seq_if.slave   bus
);

   seq_state_e             state_q;
   logic [ARAM_NUM_DW-1:0] mask_q;
   logic [ARAM_ADD_AW-1:0] base_q;
   logic [SEQ_LEN_DW-1:0]  len_q;
   logic [ARAM_ADD_AW-1:0] strd_q;
   logic                   info_vld_q;
   logic                   idle_q;
   logic                   done_q;
   logic                   empty_q;   // empty-mask job accepted last cycle

   logic [ARAM_NUM_DW-1:0]                  add_vld_s;
   logic [ARAM_NUM_DW-1:0]                  add_lst_s;
   logic [ARAM_NUM_DW-1:0][ARAM_ADD_AW-1:0] add_add_s;
   logic [ARAM_NUM_DW-1:0]                  addr_done_nx;
   logic [ARAM_NUM_DW-1:0]                  dat_done_nx;
   logic                                    job_acc;
   logic                                    cmd_hs;

   assign job_acc = idle_q & bus.cfg_vld;
   assign cmd_hs  = info_vld_q & bus.info_rdy;

   assign bus.is_idle  = idle_q;
   assign bus.cfg_rdy  = idle_q;
   assign bus.info_vld = info_vld_q;
   assign bus.info_cmd = ARAM_CMD_READ;
   assign bus.info_idx = mask_q;
   assign bus.add_vld  = add_vld_s;
   assign bus.add_lst  = add_lst_s;
   assign bus.add_add  = add_add_s;
   assign bus.done     = done_q;

   for (genvar g = 0; g < ARAM_NUM_DW; g++) begin : g_bank
      eeg_aram_bank_agu u_agu (
         .clk            (clk),
         .rst_n          (rst_n),
         .sel_i          (mask_q[g]),
         .clr_dat_i      (job_acc),
         .load_i         (cmd_hs),
         .addr_en_i      (state_q == SEQ_ADDR),
         .trk_i          (~idle_q),
         .base_i         (base_q),
         .strd_i         (strd_q),
         .len_i          (len_q),
         .add_rdy_i      (bus.add_rdy[g]),
         .mon_vld_i      (bus.mon_vld[g]),
         .mon_rdy_i      (bus.mon_rdy[g]),
         .mon_lst_i      (bus.mon_lst[g]),
         .add_vld_o      (add_vld_s[g]),
         .add_lst_o      (add_lst_s[g]),
         .add_add_o      (add_add_s[g]),
         .addr_done_nx_o (addr_done_nx[g]),
         .dat_done_nx_o  (dat_done_nx[g])
      );
   end

   // Job FSM with registered handshake/status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= SEQ_IDLE;
         mask_q     <= {ARAM_NUM_DW{1'b0}};
         base_q     <= {ARAM_ADD_AW{1'b0}};
         len_q      <= {SEQ_LEN_DW{1'b0}};
         strd_q     <= {ARAM_ADD_AW{1'b0}};
         info_vld_q <= 1'b0;
         idle_q     <= 1'b1;
         done_q     <= 1'b0;
         empty_q    <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         empty_q <= 1'b0;
         case (state_q)
            SEQ_IDLE: begin
               done_q <= empty_q;
               if (bus.cfg_vld) begin
                  mask_q <= bus.cfg_mask;
                  base_q <= bus.cfg_base;
                  len_q  <= bus.cfg_len;
                  strd_q <= bus.cfg_strd;
                  if (bus.cfg_mask == {ARAM_NUM_DW{1'b0}}) begin
                     empty_q <= 1'b1;
                  end else begin
                     state_q    <= SEQ_CMD;
                     idle_q     <= 1'b0;
                     info_vld_q <= 1'b1;
                  end
               end
            end
            SEQ_CMD: begin
               if (bus.info_rdy) begin
                  state_q    <= SEQ_ADDR;
                  info_vld_q <= 1'b0;
               end
            end
            SEQ_ADDR: begin
               if (mask_covered(addr_done_nx, mask_q)) begin
                  state_q <= SEQ_WAIT;
               end
            end
            SEQ_WAIT: begin
               if (mask_covered(dat_done_nx, mask_q)) begin
                  state_q <= SEQ_IDLE;
                  idle_q  <= 1'b1;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q    <= SEQ_IDLE;
               idle_q     <= 1'b1;
               info_vld_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eeg_aram_rd_seq.sv
// Self-checking bench for eeg_aram_rd_seq: table of read jobs plus
// hand-written corner sequences, with a per-bank address scoreboard.
module tb_eeg_aram_rd_seq;
   import eeg_aram_pkg::*;

   typedef struct {
      logic [3:0]  mask;
      logic [11:0] base;
      logic [11:0] len;
      logic [11:0] strd;
      int          rdy_mode;   // 0 all ready, 1 random, 2 none
      logic [11:0] last;       // expected final address per selected bank
      int          lat;        // accept-to-DONE cycles, 0 = not checked
   } job_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   eeg_aram_rd_seq_if bus();

   eeg_aram_rd_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   int          done_cyc = 0;
   int          acc_cyc = 0;
   int          lst_cyc = 0;
   int          rdy_mode = 0;
   bit          auto_mon = 1'b1;
   logic        info_seen = 1'b0;
   logic [3:0]  cur_mask = 4'd0;
   int          lst_seen [4] = '{default: 0};
   int          mon_sent [4] = '{default: 0};
   logic [11:0] last_addr [4];
   logic        hold_pend [4] = '{default: 1'b0};
   logic [12:0] hold_val [4];
   logic [12:0] exp_q [4][$];
   job_t        jobs [6];
   job_t        jb;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One cycle: sample/score at negedge, then drive inputs #1 after posedge.
   task automatic tick();
      logic [12:0] e;
      logic [3:0]  rdy_v, mon_v;
      @(negedge clk);
      chk("vld_unsel", 32'(bus.add_vld & ~cur_mask), 32'd0);
      if (bus.info_vld) begin
         info_seen = 1'b1;
         chk("info_idx", 32'(bus.info_idx), 32'(cur_mask));
         chk("info_cmd", 32'(bus.info_cmd), 32'h80);
      end
      if (bus.done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      for (int i = 0; i < 4; i++) begin
         if (hold_pend[i])
            chk("vld_hold", {19'd0, bus.add_vld[i], bus.add_lst[i], bus.add_add[i]},
                {19'd0, 1'b1, hold_val[i]});
         hold_pend[i] = 1'b0;
         if (bus.add_vld[i] && bus.add_rdy[i]) begin
            if (exp_q[i].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL add_unexpected bank=%0d actual=%0h required=none", i, bus.add_add[i]);
            end else begin
               e = exp_q[i].pop_front();
               chk($sformatf("add_add_b%0d", i), 32'(bus.add_add[i]), 32'(e[11:0]));
               chk($sformatf("add_lst_b%0d", i), 32'(bus.add_lst[i]), 32'(e[12]));
            end
            last_addr[i] = bus.add_add[i];
            if (bus.add_lst[i]) begin
               lst_seen[i]++;
               lst_cyc = cyc;
            end
         end else if (bus.add_vld[i]) begin
            hold_pend[i] = 1'b1;
            hold_val[i]  = {bus.add_lst[i], bus.add_add[i]};
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < 4; i++) begin
         case (rdy_mode)
            0:       rdy_v[i] = 1'b1;
            1:       rdy_v[i] = 1'($urandom_range(0, 1));
            default: rdy_v[i] = 1'b0;
         endcase
         mon_v[i] = 1'b0;
         if (auto_mon && lst_seen[i] > mon_sent[i]) begin
            mon_v[i] = 1'b1;
            mon_sent[i]++;
         end
      end
      bus.add_rdy = rdy_v;
      bus.mon_vld = mon_v;
      bus.mon_rdy = mon_v;
      bus.mon_lst = mon_v;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_is_idle"}, 32'(bus.is_idle), 32'd1);
      chk({tag, "_cfg_rdy"}, 32'(bus.cfg_rdy), 32'd1);
      chk({tag, "_info_vld"}, 32'(bus.info_vld), 32'd0);
      chk({tag, "_info_idx"}, 32'(bus.info_idx), 32'd0);
      chk({tag, "_add_vld"}, 32'(bus.add_vld), 32'd0);
      chk({tag, "_add_lst"}, 32'(bus.add_lst), 32'd0);
      chk({tag, "_add_add_nz"}, 32'(bus.add_add != 48'd0), 32'd0);
      chk({tag, "_done"}, 32'(bus.done), 32'd0);
   endtask

   // Push scoreboard entries and present the job for one cycle.
   task automatic start_job(input job_t j);
      int v;
      cur_mask  = j.mask;
      rdy_mode  = j.rdy_mode;
      info_seen = 1'b0;
      done_cnt  = 0;
      for (int i = 0; i < 4; i++) begin
         if (j.mask[i]) begin
            for (int k = 0; k <= int'(j.len); k++) begin
               v = (int'(j.base) + k * int'(j.strd)) % 4096;
               exp_q[i].push_back({(k == int'(j.len)), 12'(v)});
            end
         end
      end
      chk("cfg_rdy", 32'(bus.cfg_rdy), 32'd1);
      bus.cfg_vld  = 1'b1;
      bus.cfg_mask = j.mask;
      bus.cfg_base = j.base;
      bus.cfg_len  = j.len;
      bus.cfg_strd = j.strd;
      acc_cyc = cyc;
      tick();
      bus.cfg_vld = 1'b0;
   endtask

   // Wait (bounded) for DONE and check the job's end state.
   task automatic finish_job(input job_t j, input string tag);
      int n = 0;
      while (done_cnt == 0 && n < 400) begin
         tick();
         n++;
      end
      if (done_cnt == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout actual=no_done required=done", tag);
      end
      repeat (3) tick();
      chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      if (j.lat != 0) chk({tag, "_done_lat"}, 32'(done_cyc - acc_cyc), 32'(j.lat));
      for (int i = 0; i < 4; i++) begin
         if (j.mask[i]) chk($sformatf("%s_last_b%0d", tag, i), 32'(last_addr[i]), 32'(j.last));
         chk($sformatf("%s_sb_left_b%0d", tag, i), 32'(exp_q[i].size()), 32'd0);
      end
      chk({tag, "_info_seen"}, 32'(info_seen), 32'(j.mask != 4'd0));
      chk({tag, "_is_idle"}, 32'(bus.is_idle), 32'd1);
   endtask

   initial begin
      jobs[0] = '{mask: 4'b0001, base: 12'h010, len: 12'd3, strd: 12'd2,  rdy_mode: 0, last: 12'h016, lat: 7};
      jobs[1] = '{mask: 4'b1111, base: 12'h100, len: 12'd7, strd: 12'd1,  rdy_mode: 1, last: 12'h107, lat: 0};
      jobs[2] = '{mask: 4'b0010, base: 12'hFFE, len: 12'd2, strd: 12'd1,  rdy_mode: 0, last: 12'h000, lat: 6};
      jobs[3] = '{mask: 4'b0001, base: 12'h055, len: 12'd0, strd: 12'd5,  rdy_mode: 0, last: 12'h055, lat: 4};
      jobs[4] = '{mask: 4'b1010, base: 12'h7F0, len: 12'd4, strd: 12'h00C, rdy_mode: 1, last: 12'h820, lat: 0};
      jobs[5] = '{mask: 4'b0000, base: 12'h123, len: 12'd3, strd: 12'd1,  rdy_mode: 0, last: 12'h000, lat: 2};

      rst_n        = 1'b0;
      bus.cfg_vld  = 1'b0;
      bus.cfg_mask = 4'd0;
      bus.cfg_base = 12'd0;
      bus.cfg_len  = 12'd0;
      bus.cfg_strd = 12'd0;
      bus.info_rdy = 1'b1;
      bus.add_rdy  = 4'd0;
      bus.mon_vld  = 4'd0;
      bus.mon_rdy  = 4'd0;
      bus.mon_lst  = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      rst_n = 1'b1;
      tick();

      for (int j = 0; j < 6; j++) begin
         start_job(jobs[j]);
         finish_job(jobs[j], $sformatf("job%0d", j));
      end

      // Command backpressure: INFO_RDY low for five cycles.
      jb = '{mask: 4'b1000, base: 12'h200, len: 12'd1, strd: 12'd3, rdy_mode: 0, last: 12'h203, lat: 10};
      bus.info_rdy = 1'b0;
      start_job(jb);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("bp_info_vld", 32'(bus.info_vld), 32'd1);
         chk("bp_add_vld", 32'(bus.add_vld), 32'd0);
      end
      bus.info_rdy = 1'b1;
      finish_job(jb, "bp");

      // Early completion: bank 2 data end arrives while its addresses are stalled.
      jb = '{mask: 4'b0100, base: 12'h030, len: 12'd3, strd: 12'd1, rdy_mode: 2, last: 12'h033, lat: 0};
      auto_mon = 1'b0;
      start_job(jb);
      tick();
      bus.mon_vld = 4'b0100;
      bus.mon_rdy = 4'b0100;
      bus.mon_lst = 4'b0100;
      repeat (4) tick();
      chk("early_no_done", 32'(done_cnt), 32'd0);
      rdy_mode = 0;
      finish_job(jb, "early");
      chk("early_order", 32'(done_cyc > lst_cyc), 32'd1);
      for (int i = 0; i < 4; i++) mon_sent[i] = lst_seen[i];
      auto_mon = 1'b1;

      // Reset during ADDR with three beats still pending.
      jb = '{mask: 4'b0001, base: 12'h300, len: 12'd5, strd: 12'd1, rdy_mode: 0, last: 12'h305, lat: 9};
      start_job(jb);
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      repeat (2) tick();
      chk("midrst_done", 32'(done_cnt), 32'd0);
      chk("midrst_sb_left", 32'(exp_q[0].size()), 32'd3);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_q[i].delete();
         hold_pend[i] = 1'b0;
      end
      tick();
      start_job(jb);
      finish_job(jb, "postrst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/eeg_aram_rd_seq.md
# eeg_aram_rd_seq

Read sequencer for the multi-bank activation RAM (ARAM). It accepts one read job (bank mask, base address, length, stride) and issues the READ command on the ARAM config handshake. It then drives a strided address stream into every selected bank, marking the final address with LST. It finishes when every selected bank has returned its last data beat, then pulses DONE. It sits between the layer controller and the ARAM ETOA_ADD/ATOE_DAT ports; the data path itself bypasses this block.

## Interface
- ARAM_CMD_DW, 8: ARAM command width (one-hot state encoding).
- ARAM_NUM_DW, 4: number of ARAM banks.
- ARAM_ADD_AW, 12: bank address width.
- SEQ_LEN_DW, 12: job length field width.
- ARAM_CMD_READ, 8'b1000_0000: command code sent for a read job.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- IS_IDLE  out  1  high in IDLE.
- CFG_VLD  in  1  job request.
- CFG_RDY  out  1  equals IS_IDLE.
- CFG_MASK  in  ARAM_NUM_DW  banks to read.
- CFG_BASE  in  ARAM_ADD_AW  first address.
- CFG_LEN  in  SEQ_LEN_DW  beats per bank minus 1.
- CFG_STRD  in  ARAM_ADD_AW  address increment.
- ARAM_INFO_VLD  out  1  command to ARAM.
- ARAM_INFO_RDY  in  1  ARAM accepts command.
- ARAM_INFO_CMD  out  ARAM_CMD_DW  always ARAM_CMD_READ.
- ARAM_INFO_IDX  out  ARAM_NUM_DW  latched mask.
- ADD_VLD / ADD_LST  out  ARAM_NUM_DW  per-bank address valid / last.
- ADD_RDY  in  ARAM_NUM_DW  per-bank address ready.
- ADD_ADD  out  ARAM_NUM_DW x ARAM_ADD_AW  per-bank address.
- MON_VLD / MON_RDY / MON_LST  in  ARAM_NUM_DW  taps of ATOE_DAT handshake, used only for completion.
- DONE  out  1  one-cycle job-complete pulse.

## Operation
- States: IDLE, CMD, ADDR, WAIT.
- **IDLE**
  - On CFG_VLD&CFG_RDY, latch all CFG_* fields.
  - If CFG_MASK==0, go directly to IDLE with a DONE pulse next cycle; no command is issued.
  - Otherwise go to CMD.
- **CMD**
  - ARAM_INFO_VLD=1.
  - On ARAM_INFO_RDY, clear per-bank counters, load per-bank address registers with base, and go to ADDR.
- **ADDR**
  - Each bank i with mask[i]=1 and not addr_done[i] drives ADD_VLD[i]=1.
  - ADD_ADD[i] holds the current address register for bank i.
  - ADD_LST[i]=(cnt[i]==len).
  - Per-bank on ADD_VLD&ADD_RDY:
    - if LST, set addr_done[i];
    - otherwise cnt[i]+1 and addr[i]+=stride, wrapping modulo 2^ARAM_ADD_AW with no saturation.
  - Banks advance independently.
  - Go to WAIT when addr_done covers the mask.
- **WAIT**
  - Go to IDLE when dat_done covers the mask.
  - DONE pulses in the first IDLE cycle (registered).
- **Completion tracking**
  - dat_done[i] is set by MON_VLD&MON_RDY&MON_LST in CMD, ADDR or WAIT.
  - Completion can therefore occur before ADDR ends; this is counted, not lost.
  - dat_done is cleared on job accept.
  - If the last bank's data end and its final address handshake coincide, the block moves ADDR→WAIT→IDLE on consecutive cycles; no hang.
- **Unselected banks:** ADD_VLD=0, ADD_LST=0, ADD_ADD=0; their MON events are ignored.
- **CFG_LEN=0:** a single beat per bank, with LST on the first address.

## Timing
- **Reset values:** state IDLE, IS_IDLE=1, CFG_RDY=1, ARAM_INFO_VLD=0, ARAM_INFO_IDX=0, ADD_VLD=0, ADD_LST=0, ADD_ADD=0, DONE=0. All counters and flags are 0.
- **Reset mid-operation** aborts immediately to these values; no DONE is produced.
- **Output timing:** ARAM_INFO_VLD, ADD_VLD, ADD_LST and ADD_ADD are decoded from registers only; there are no combinational paths from RDY inputs.
- **VLD hold rule:** once VLD is high it holds until the handshake, with stable address/LST.
- **Accept to command:** accept → ARAM_INFO_VLD high next cycle.
- **Command to addresses:** command handshake → first ADD_VLD next cycle.
- **Throughput:** one address per bank per cycle under continuous ADD_RDY.
- **Minimum job** (1 bank, LEN=0, all ready, data returned 1 cycle later): accept@0, CMD@1, ADDR@2, WAIT@3, data end@3, IDLE+DONE@4.

## Structure
- **Shared package** `eeg_aram_pkg`:
  - ARAM command one-hot constants (IDLE, ITOA, CONV, OTOA, WTOA, ATOW, ATOA, READ);
  - the sequencer state encoding.
- **Sub-module** `eeg_aram_bank_agu`: per-bank counter, address accumulator, addr_done/dat_done flags. Instantiate it ARAM_NUM_DW times; the top holds the FSM and the CFG/INFO handshakes.

## Test plan
- **Single bank, full throughput:** mask=4'b0001, base=0x010, len=3, strd=2, ADD_RDY held high → bank 0 addresses 0x010, 0x012, 0x014, 0x016, LST on 0x016; banks 1–3 VLD never high; DONE one cycle after MON_LST[0].
- **Four banks, staggered ready:** mask=4'hF, base=0x100, len=7, strd=1, random ADD_RDY per bank → each bank sees exactly 0x100..0x107 in order; WAIT entered only after the slowest bank's LST.
- **Wrap-around:** mask=4'b0010, base=0xFFE, len=2, strd=1 → addresses 0xFFE, 0xFFF, 0x000.
- **Early completion and empty mask:**
  - MON_LST for bank 2 during ADDR (mask=4'b0100) → DONE still fires once after ADDR ends.
  - mask=0 → no ARAM_INFO_VLD; DONE two cycles after accept.
- **Command backpressure:** ARAM_INFO_RDY low for 5 cycles → VLD held, IDX=mask stable, no ADD_VLD until the handshake.
- **Reset mid-job:** rst_n low during ADDR with 3 beats pending → all outputs at reset values; the next job runs cleanly from base.
